// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO fabric: FSM states, default address map,
// error read value and the layout of the internal status register.
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [11:0] MEM_END  = 12'hBFF;
  localparam logic [11:0] KEYPAD   = 12'hC10;
  localparam logic [11:0] DISPLAY1 = 12'hC20;
  localparam logic [11:0] DISPLAY2 = 12'hC30;
  localparam logic [11:0] STATUS   = 12'hCF0;

  localparam logic [15:0] ERR_DATA_DEFAULT = 16'hFFFF;

  localparam int STAT_STICKY  = 0;
  localparam int STAT_KIND    = 1;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_W   = 8;

  // Status word after one more error: sticky set, kind recorded, count saturates.
  function automatic logic [15:0] statusOnError(input logic [15:0] cur, input logic isTimeout);
    logic [STAT_CNT_W-1:0] cnt;
    logic [15:0]           nxt;
    cnt = cur[STAT_CNT_LSB +: STAT_CNT_W];
    if (cnt != {STAT_CNT_W{1'b1}}) cnt = cnt + 1'b1;
    nxt = '0;
    nxt[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
    nxt[STAT_KIND]   = isTimeout;
    nxt[STAT_STICKY] = 1'b1;
    return nxt;
  endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Table-driven address decode: finds the lowest-index channel window that
// contains the address, and flags the two internal status registers.
module mmio_addr_decode #(
  parameter int                         N_PERIPH    = 4,
  parameter int                         ADDR_W      = 12,
  parameter logic [N_PERIPH*ADDR_W-1:0] BASE        = '0,
  parameter logic [N_PERIPH*ADDR_W-1:0] LIMIT       = '0,
  parameter logic [ADDR_W-1:0]          STATUS_ADDR = '0,
  localparam int                        IDX_W       = (N_PERIPH > 1) ? $clog2(N_PERIPH) : 1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx,
  output logic              internal
);

  localparam logic [ADDR_W-1:0] ERR_ADDR_REG = STATUS_ADDR + 1'b1;

  // Scan from the top down so the lowest matching index is the one left standing;
  // the internal registers take priority over any channel window.
  always_comb begin
    hit      = 1'b0;
    idx      = '0;
    internal = (addr == STATUS_ADDR) || (addr == ERR_ADDR_REG);
    for (int i = N_PERIPH - 1; i >= 0; i--) begin
      if ((addr >= BASE[i*ADDR_W +: ADDR_W]) && (addr <= LIMIT[i*ADDR_W +: ADDR_W])) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
    if (internal) hit = 1'b0;
  end

endmodule

// File: rtl/mmio_bus_fabric.sv
// CPU-to-peripheral memory-mapped interconnect: hold-until-ack handshake,
// per-access timeout, and a software-visible bus-error status block.
module mmio_bus_fabric
  import mmio_pkg::*;
#(
  parameter int                         N_PERIPH    = 4,
  parameter int                         ADDR_W      = 12,
  parameter int                         DATA_W      = 16,
  parameter logic [N_PERIPH*ADDR_W-1:0] BASE        = {DISPLAY2, DISPLAY1, KEYPAD, 12'h000},
  parameter logic [N_PERIPH*ADDR_W-1:0] LIMIT       = {DISPLAY2, DISPLAY1, KEYPAD + 12'h001, MEM_END},
  parameter logic [ADDR_W-1:0]          STATUS_ADDR = STATUS,
  parameter int                         TIMEOUT_CYC = 15,
  parameter logic [DATA_W-1:0]          ERR_DATA    = ERR_DATA_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_ack,
  output logic                         cpu_busy,
  output logic [N_PERIPH-1:0]          per_sel,
  output logic                         per_we,
  output logic [ADDR_W-1:0]            per_addr,
  output logic [DATA_W-1:0]            per_wdata,
  input  logic [N_PERIPH*DATA_W-1:0]   per_rdata,
  input  logic [N_PERIPH-1:0]          per_ack,
  output logic                         bus_err
);

  localparam int IDX_W = (N_PERIPH > 1) ? $clog2(N_PERIPH) : 1;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [N_PERIPH-1:0]   sel_q, sel_d;
  logic                  perWe_q, perWe_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  ack_q, ack_d;
  logic [15:0]           status_q, status_d;
  logic [ADDR_W-1:0]     errAddr_q, errAddr_d;

  logic                  decHit;
  logic [IDX_W-1:0]      decIdx;
  logic                  decInternal;
  logic                  ackSel;
  logic [DATA_W-1:0]     selRdata;

  mmio_addr_decode #(
    .N_PERIPH    (N_PERIPH),
    .ADDR_W      (ADDR_W),
    .BASE        (BASE),
    .LIMIT       (LIMIT),
    .STATUS_ADDR (STATUS_ADDR)
  ) u_decode (
    .addr     (cpu_addr),
    .hit      (decHit),
    .idx      (decIdx),
    .internal (decInternal)
  );

  // Only the selected channel's ack and data count; others are masked by sel_q.
  always_comb begin
    ackSel   = |(per_ack & sel_q);
    selRdata = '0;
    for (int i = 0; i < N_PERIPH; i++) begin
      if (sel_q[i]) selRdata = selRdata | per_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    sel_d     = sel_q;
    perWe_d   = perWe_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;
    status_d  = status_q;
    errAddr_d = errAddr_q;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          we_d    = cpu_we;
          if (decInternal) begin
            state_d = ST_DONE;
            if (cpu_addr == STATUS_ADDR) begin
              if (cpu_we) begin
                if (cpu_wdata[0]) status_d = '0;
              end else begin
                rdata_d = DATA_W'(status_q);
              end
            end else if (!cpu_we) begin
              rdata_d = DATA_W'(errAddr_q);
            end
          end else if (decHit) begin
            state_d = ST_ACCESS;
            sel_d   = N_PERIPH'(1) << decIdx;
            perWe_d = cpu_we;
            cnt_d   = '0;
          end else begin
            state_d   = ST_DONE;
            status_d  = statusOnError(status_q, 1'b0);
            errAddr_d = cpu_addr;
            if (!cpu_we) rdata_d = ERR_DATA;
          end
        end
      end

      // Ack is checked before the timeout so a late-but-valid ack still completes normally.
      ST_ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        if (ackSel) begin
          state_d = ST_DONE;
          sel_d   = '0;
          perWe_d = 1'b0;
          if (!we_q) rdata_d = selRdata;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = ST_DONE;
          sel_d     = '0;
          perWe_d   = 1'b0;
          status_d  = statusOnError(status_q, 1'b1);
          errAddr_d = addr_q;
          if (!we_q) rdata_d = ERR_DATA;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        ack_d   = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
        perWe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      perWe_q   <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      status_q  <= '0;
      errAddr_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      perWe_q   <= perWe_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      status_q  <= status_d;
      errAddr_q <= errAddr_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ack   = ack_q;
  assign cpu_busy  = (state_q != ST_IDLE);
  assign per_sel   = sel_q;
  assign per_we    = perWe_q;
  assign per_addr  = addr_q;
  assign per_wdata = wdata_q;
  assign bus_err   = status_q[STAT_STICKY];

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Self-checking bench for mmio_bus_fabric: directed and random transactions
// compared against a transaction-level model of the address map and status block.
module tb_mmio_bus_fabric;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [11:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_busy;
  logic [3:0]  per_sel;
  logic        per_we;
  logic [11:0] per_addr;
  logic [15:0] per_wdata;
  logic [63:0] perRdata;
  logic [3:0]  perAck;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  // Peripheral responder: acks on channel ackCh during ACCESS cycle ackAfter (0 = never).
  int ackAfter    = 0;
  int ackCh       = 0;
  int accessCount = 0;

  // Transaction-level model state.
  int          mSticky = 0;
  int          mKind   = 0;
  int          mCount  = 0;
  logic [11:0] mErrAddr = '0;

  always #5 clk = ~clk;

  mmio_bus_fabric dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_busy  (cpu_busy),
    .per_sel   (per_sel),
    .per_we    (per_we),
    .per_addr  (per_addr),
    .per_wdata (per_wdata),
    .per_rdata (perRdata),
    .per_ack   (perAck),
    .bus_err   (bus_err)
  );

  // The responder counts how long a channel has been selected.
  always @(posedge clk) begin
    if (reset || per_sel == 4'b0) accessCount <= 0;
    else                          accessCount <= accessCount + 1;
  end

  assign perAck = (per_sel != 4'b0 && ackAfter != 0 && accessCount + 1 == ackAfter)
                  ? 4'(1 << ackCh) : 4'b0;

  // Map knowledge: 10 = status reg, 11 = error-address reg, -1 = unmapped.
  function automatic int modelTarget(input logic [11:0] a);
    if (a == 12'hCF0) return 10;
    if (a == 12'hCF1) return 11;
    if (a <= 12'hBFF) return 0;
    if (a == 12'hC10 || a == 12'hC11) return 1;
    if (a == 12'hC20) return 2;
    if (a == 12'hC30) return 3;
    return -1;
  endfunction

  function automatic logic [15:0] statusWord();
    return {8'(mCount), 6'b0, 1'(mKind), 1'(mSticky)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One complete CPU transaction with model prediction and checks.
  task automatic applyStimulus(input logic we, input logic [11:0] addr, input logic [15:0] wdata,
                               input int ackAfterIn, input int ackChIn);
    int          tgt;
    int          expLat;
    int          n;
    logic [15:0] expData;
    logic        expErr;
    logic        expTimeout;

    tgt        = modelTarget(addr);
    perRdata   = {$urandom, $urandom};
    expErr     = 1'b0;
    expTimeout = 1'b0;
    expData    = 16'h0;
    expLat     = 2;
    if (tgt == 10) begin
      if (we) begin
        if (wdata[0]) begin
          mSticky = 0; mKind = 0; mCount = 0;
        end
      end else begin
        expData = statusWord();
      end
    end else if (tgt == 11) begin
      expData = {4'b0, mErrAddr};
    end else if (tgt < 0) begin
      expErr  = 1'b1;
      expData = 16'hFFFF;
    end else if (ackChIn == tgt && ackAfterIn >= 1 && ackAfterIn <= TO) begin
      expLat  = 2 + ackAfterIn;
      expData = perRdata[tgt*16 +: 16];
    end else begin
      expLat     = 2 + TO;
      expErr     = 1'b1;
      expTimeout = 1'b1;
      expData    = 16'hFFFF;
    end

    @(negedge clk);
    ackAfter  = ackAfterIn;
    ackCh     = ackChIn;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    n = 1;
    checkOutput("busy@accept", cpu_busy, 1);
    checkOutput("per_sel@accept", per_sel, (tgt >= 0 && tgt < 4) ? (1 << tgt) : 0);
    if (tgt >= 0 && tgt < 4) begin
      checkOutput("per_we", per_we, we);
      checkOutput("per_addr", per_addr, addr);
      if (we) checkOutput("per_wdata", per_wdata, wdata);
    end
    while (!cpu_ack && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (expErr) begin
      if (mCount < 255) mCount++;
      mSticky  = 1;
      mKind    = expTimeout ? 1 : 0;
      mErrAddr = addr;
    end
    checkOutput("latency", n, expLat);
    if (!we) checkOutput("rdata", cpu_rdata, expData);
    checkOutput("bus_err", bus_err, mSticky);
    @(posedge clk); #1;
    checkOutput("ack single pulse", cpu_ack, 0);
    checkOutput("idle after ack", cpu_busy, 0);
    ackAfter = 0;
  endtask

  initial begin
    int          kind;
    logic [11:0] a;

    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    perRdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset cpu_ack", cpu_ack, 0);
    checkOutput("reset cpu_rdata", cpu_rdata, 0);
    checkOutput("reset per_sel", per_sel, 0);
    checkOutput("reset per_we", per_we, 0);
    checkOutput("reset per_addr", per_addr, 0);
    checkOutput("reset per_wdata", per_wdata, 0);
    checkOutput("reset bus_err", bus_err, 0);
    checkOutput("reset busy", cpu_busy, 0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] directed map and error cases");
    applyStimulus(1'b0, 12'h005, 16'h0, 1, 0);
    applyStimulus(1'b1, 12'hC20, 16'h1234, 1, 2);
    applyStimulus(1'b0, 12'hC40, 16'h0, 0, 0);
    applyStimulus(1'b0, 12'hCF0, 16'h0, 0, 0);
    applyStimulus(1'b0, 12'hCF1, 16'h0, 0, 0);
    applyStimulus(1'b0, 12'hC10, 16'h0, 0, 1);
    applyStimulus(1'b0, 12'hCF0, 16'h0, 0, 0);
    applyStimulus(1'b0, 12'hC11, 16'h0, TO, 1);
    applyStimulus(1'b1, 12'hCF0, 16'h0001, 0, 0);
    applyStimulus(1'b0, 12'hCF0, 16'h0, 0, 0);
    applyStimulus(1'b0, 12'hC30, 16'h0, 1, 0);
    applyStimulus(1'b1, 12'hCF1, 16'hFFFF, 0, 0);
    applyStimulus(1'b0, 12'hCF1, 16'h0, 0, 0);

    $display("[TB] random transactions");
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: applyStimulus(1'b0, 12'($urandom_range(0, 12'hBFF)), 16'h0, $urandom_range(1, 4), 0);
        1: applyStimulus(1'b1, 12'($urandom_range(0, 12'hBFF)), 16'($urandom), $urandom_range(1, 4), 0);
        2: applyStimulus(1'b0, 12'hC10 + 12'($urandom_range(0, 1)), 16'h0, $urandom_range(0, TO), 1);
        3: begin
          a = $urandom_range(0, 1) ? 12'hC20 : 12'hC30;
          applyStimulus(1'b1, a, 16'($urandom), $urandom_range(1, 6), (a == 12'hC20) ? 2 : 3);
        end
        4: begin
          a = $urandom_range(0, 1) ? 12'($urandom_range(12'hD00, 12'hFFF))
                                   : 12'hC12 + 12'($urandom_range(0, 13));
          applyStimulus(1'b0, a, 16'h0, 0, 0);
        end
        default: applyStimulus(1'b0, 12'hCF0 + 12'($urandom_range(0, 1)), 16'h0, 0, 0);
      endcase
    end

    $display("[TB] back-to-back requests and mid-access reset");
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 12'hCF1;
    @(posedge clk); #1;
    checkOutput("b2b busy1", cpu_busy, 1);
    @(posedge clk); #1;
    checkOutput("b2b ack1", cpu_ack, 1);
    checkOutput("b2b rdata1", cpu_rdata, {4'b0, mErrAddr});
    @(posedge clk); #1;
    checkOutput("b2b ack gap", cpu_ack, 0);
    checkOutput("b2b busy2", cpu_busy, 1);
    @(posedge clk); #1;
    checkOutput("b2b ack2", cpu_ack, 1);
    ackAfter = 0;
    cpu_addr = 12'h010;
    @(posedge clk); #1;
    checkOutput("b2b per_sel", per_sel, 4'b0001);
    cpu_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid reset per_sel", per_sel, 0);
    checkOutput("mid reset ack", cpu_ack, 0);
    checkOutput("mid reset busy", cpu_busy, 0);
    checkOutput("mid reset bus_err", bus_err, 0);
    @(negedge clk);
    reset = 1'b0;
    mSticky = 0; mKind = 0; mCount = 0; mErrAddr = '0;
    @(posedge clk); #1;
    checkOutput("no late ack", cpu_ack, 0);
    applyStimulus(1'b0, 12'hCF0, 16'h0, 0, 0);
    applyStimulus(1'b0, 12'hCF1, 16'h0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
